// File: rtl/gba_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gba_mem_pkg                                                                |
// | Shared constants and types for the GBA memory-bus slave.                   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package gba_mem_pkg;

  localparam int c_cnt_w = 4;

  localparam logic [2:0] c_reg_bios  = 3'd0;
  localparam logic [2:0] c_reg_ewram = 3'd1;
  localparam logic [2:0] c_reg_iwram = 3'd2;
  localparam logic [2:0] c_reg_io    = 3'd3;
  localparam logic [2:0] c_reg_rom   = 3'd4;

  localparam logic [7:0] c_base_bios   = 8'h00;
  localparam logic [7:0] c_base_ewram  = 8'h02;
  localparam logic [7:0] c_base_iwram  = 8'h03;
  localparam logic [7:0] c_base_io     = 8'h04;
  localparam logic [7:0] c_base_rom_lo = 8'h08;
  localparam logic [7:0] c_base_rom_hi = 8'h0D;

  localparam logic [31:0] c_waitcnt_addr = 32'h0400_0204;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  function automatic logic [c_cnt_w-1:0] rom_wait_lut(input logic [1:0] sel);
    case (sel)
      2'd0:    return 4'd4;
      2'd1:    return 4'd3;
      2'd2:    return 4'd2;
      default: return 4'd8;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/gba_lane_fmt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gba_lane_fmt                                                               |
// | Byte-enable generation, write lane replication, read extract/rotate.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module gba_lane_fmt (
  input  logic [1:0]  width,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_fmt
);

  logic [63:0] w_dbl;

  // Shifting a doubled copy yields the word rotate and byte extract in one go
  assign w_dbl = {rdata_raw, rdata_raw} >> {offset, 3'b000};

  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    rdata_fmt = w_dbl[31:0];
    case (width)
      2'd0: begin
        be        = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
        rdata_fmt = {24'h0, w_dbl[7:0]};
      end
      2'd1: begin
        be        = offset[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_fmt = {16'h0, (offset[1] ? rdata_raw[31:16] : rdata_raw[15:0])};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_fmt = w_dbl[31:0];
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/gba_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gba_mem_ctrl                                                               |
// | GBA memory-bus slave: region decode, wait states, device port, read data.  |
// | Optional macro GBA_WAITCNT_EN adds an internal WAITCNT register.           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module gba_mem_ctrl
  import gba_mem_pkg::*;
#(
  parameter int BIOS_WAIT  = 0,
  parameter int EWRAM_WAIT = 2,
  parameter int IWRAM_WAIT = 0,
  parameter int IO_WAIT    = 0,
  parameter int ROM_WAIT   = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  input  logic [1:0]  mem_width,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic        mem_ok,
  output logic [2:0]  dev_region,
  output logic [31:0] dev_addr,
  output logic [31:0] dev_wdata,
  output logic [3:0]  dev_be,
  output logic        dev_re,
  output logic        dev_we,
  input  logic [31:0] dev_rdata
);

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [1:0]           r_off, r_width;
  logic                 r_wr, r_mapped, r_dev_acc, r_mem_ok;
  logic                 r_dev_re, r_dev_we;
  logic [2:0]           r_dev_region;
  logic [31:0]          r_dev_addr, r_dev_wdata;
  logic [3:0]           r_dev_be;

  logic                 w_mapped, w_int, w_dev_acc;
  logic [2:0]           w_region;
  logic [c_cnt_w-1:0]   w_wait, w_rom_wait;
  logic [1:0]           w_fmt_width, w_fmt_off;
  logic [31:0]          w_raw, w_wdata_rep, w_rdata_fmt;
  logic [3:0]           w_be;

`ifdef GBA_WAITCNT_EN
  logic [15:0] r_waitcnt;
  logic        r_int;
  assign w_int      = (mem_addr[31:2] == c_waitcnt_addr[31:2]);
  assign w_rom_wait = rom_wait_lut(r_waitcnt[3:2]);
  assign w_raw      = r_int ? {16'h0, r_waitcnt} : dev_rdata;
`else
  assign w_int      = 1'b0;
  assign w_rom_wait = c_cnt_w'(ROM_WAIT);
  assign w_raw      = dev_rdata;
`endif

  // Decode on the full top byte so addresses above 0x0F land as unmapped
  always_comb begin
    w_mapped = 1'b1;
    w_region = c_reg_bios;
    w_wait   = c_cnt_w'(BIOS_WAIT);
    if (mem_addr[31:24] == c_base_bios) begin
      w_region = c_reg_bios;
      w_wait   = c_cnt_w'(BIOS_WAIT);
    end else if (mem_addr[31:24] == c_base_ewram) begin
      w_region = c_reg_ewram;
      w_wait   = c_cnt_w'(EWRAM_WAIT);
    end else if (mem_addr[31:24] == c_base_iwram) begin
      w_region = c_reg_iwram;
      w_wait   = c_cnt_w'(IWRAM_WAIT);
    end else if (mem_addr[31:24] == c_base_io) begin
      w_region = c_reg_io;
      w_wait   = c_cnt_w'(IO_WAIT);
    end else if (mem_addr[31:24] >= c_base_rom_lo && mem_addr[31:24] <= c_base_rom_hi) begin
      w_region = c_reg_rom;
      w_wait   = w_rom_wait;
    end else begin
      w_mapped = 1'b0;
      w_region = c_reg_bios;
      w_wait   = '0;
    end
  end

  assign w_dev_acc = w_mapped && !w_int &&
                     !(mem_write && (w_region == c_reg_bios || w_region == c_reg_rom));

  // Live request drives the formatter while idle; the latched one afterwards
  assign w_fmt_width = (r_state == ST_IDLE) ? mem_width     : r_width;
  assign w_fmt_off   = (r_state == ST_IDLE) ? mem_addr[1:0] : r_off;

  gba_lane_fmt u_lane_fmt (
    .width     (w_fmt_width),
    .offset    (w_fmt_off),
    .wdata     (mem_wdata),
    .rdata_raw (w_raw),
    .be        (w_be),
    .wdata_rep (w_wdata_rep),
    .rdata_fmt (w_rdata_fmt)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_off        <= '0;
      r_width      <= '0;
      r_wr         <= 1'b0;
      r_mapped     <= 1'b0;
      r_dev_acc    <= 1'b0;
      r_mem_ok     <= 1'b0;
      r_dev_re     <= 1'b0;
      r_dev_we     <= 1'b0;
      r_dev_region <= '0;
      r_dev_addr   <= '0;
      r_dev_wdata  <= '0;
      r_dev_be     <= '0;
`ifdef GBA_WAITCNT_EN
      r_waitcnt    <= 16'h0000;
      r_int        <= 1'b0;
`endif
    end else begin
      r_dev_re <= 1'b0;
      r_dev_we <= 1'b0;
      r_mem_ok <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (mem_read || mem_write) begin
            r_off        <= mem_addr[1:0];
            r_width      <= mem_width;
            r_wr         <= mem_write;
            r_mapped     <= w_mapped;
            r_dev_acc    <= w_dev_acc;
            r_dev_region <= w_region;
            r_dev_addr   <= {mem_addr[31:2], 2'b00};
            r_dev_wdata  <= w_wdata_rep;
            r_dev_be     <= w_be;
            r_cnt        <= w_wait;
`ifdef GBA_WAITCNT_EN
            r_int        <= w_int;
`endif
            if (w_wait == '0) begin
              r_state  <= ST_ACCESS;
              r_dev_re <= w_dev_acc && !mem_write;
              r_dev_we <= w_dev_acc && mem_write;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - c_cnt_w'(1);
          if (r_cnt == c_cnt_w'(1)) begin
            r_state  <= ST_ACCESS;
            r_dev_re <= r_dev_acc && !r_wr;
            r_dev_we <= r_dev_acc && r_wr;
          end
        end
        ST_ACCESS: begin
          r_state  <= ST_RESP;
          r_mem_ok <= 1'b1;
`ifdef GBA_WAITCNT_EN
          if (r_int && r_wr) begin
            if (r_dev_be[0]) r_waitcnt[7:0]  <= r_dev_wdata[7:0];
            if (r_dev_be[1]) r_waitcnt[15:8] <= r_dev_wdata[15:8];
          end
`endif
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_ok     = r_mem_ok;
  assign mem_rdata  = (r_mem_ok && !r_wr && r_mapped) ? w_rdata_fmt : 32'h0;
  assign dev_re     = r_dev_re;
  assign dev_we     = r_dev_we;
  assign dev_be     = r_dev_be;
  assign dev_addr   = r_dev_addr;
  assign dev_wdata  = r_dev_wdata;
  assign dev_region = r_dev_region;

endmodule
`default_nettype wire
